// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//   Multi-cycle two's-complement adder/subtractor. Operands are latched on an
//   input handshake. The sum is then formed CHUNK bits per clock, LSB chunk
//   first, with a registered ripple carry between chunks. The finished result
//   is held on S/Cout/Ovf until the output handshake completes.
//
// Parameters
//   WIDTH     operand/result width in bits (>= 1)
//   CHUNK     bits processed per CALC cycle; must divide WIDTH
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  operand set present
//   in_ready  block can accept operands (IDLE only)
//   A, B      operands
//   Cin       carry-in (add) / borrow-in (sub)
//   Sub       0: A+B+Cin, 1: A-B-Cin
//   out_valid result available (DONE)
//   out_ready consumer takes the result
//   S         registered result
//   Cout      carry out of the MSB (sub: 1 = no borrow)
//   Ovf       two's-complement signed overflow
// -----------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("serial_addsub: CHUNK must be in 1..WIDTH and divide WIDTH");
        end
    endgenerate

    // Control and result registers (reset)
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Working registers (no reset; only meaningful after an accept)
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;

    // Operands are shifted right each CALC cycle so the active chunk is always
    // in the low CHUNK bits; partial sums are shifted in from the top so the
    // first chunk ends up at bit 0 after NCHUNK cycles.
    logic [CHUNK-1:0]       a_chunk, b_chunk;
    logic [CHUNK:0]         csum;
    logic [WIDTH+CHUNK-1:0] a_ext, b_ext, sum_ext;
    logic [WIDTH-1:0]       a_shift, b_shift, sum_shift;
    logic                   msb_cin;

    assign a_chunk   = a_q[CHUNK-1:0];
    assign b_chunk   = b_q[CHUNK-1:0];
    assign csum      = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    assign a_ext     = {{CHUNK{1'b0}}, a_q};
    assign b_ext     = {{CHUNK{1'b0}}, b_q};
    assign sum_ext   = {csum[CHUNK-1:0], sum_q};
    assign a_shift   = a_ext[WIDTH+CHUNK-1:CHUNK];
    assign b_shift   = b_ext[WIDTH+CHUNK-1:CHUNK];
    assign sum_shift = sum_ext[WIDTH+CHUNK-1:CHUNK];
    // Carry into a bit equals a ^ b ^ sum of that bit; used for the MSB of the
    // last chunk to form signed overflow.
    assign msb_cin   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ csum[CHUNK-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B ^ {WIDTH{Sub}};
                    carry_d = Cin ^ Sub;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d     = a_shift;
                b_d     = b_shift;
                sum_d   = sum_shift;
                carry_d = csum[CHUNK];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CHUNK) begin
                    s_d     = sum_shift;
                    cout_d  = csum[CHUNK];
                    ovf_d   = msb_cin ^ csum[CHUNK];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_q     <= b_d;
        sum_q   <= sum_d;
        carry_q <= carry_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] A, B, S;
    logic        Cin, Sub;
    logic        out_valid, out_ready;
    logic        Cout, Ovf;

    int   checks = 0;
    int   errors = 0;
    logic sweep_go = 1'b0;

    serial_addsub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .Cout(Cout), .Ovf(Ovf)
    );

    // Parameter sweep: one independent instance and driver per configuration.
    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int W = (g == 0) ? 16 : (g == 1) ? 16 : (g == 2) ? 8 : 1;
        localparam int C = (g == 0) ? 1  : (g == 1) ? 16 : (g == 2) ? 2 : 1;
        localparam int N = W / C;

        logic         iv, ir, ov, ordy, ci, su, co, vf;
        logic [W-1:0] ai, bi, s;
        logic         done = 1'b0;

        serial_addsub #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(iv), .in_ready(ir),
            .A(ai), .B(bi), .Cin(ci), .Sub(su),
            .out_valid(ov), .out_ready(ordy),
            .S(s), .Cout(co), .Ovf(vf)
        );

        initial begin
            logic [W-1:0] a, b, beff, exp_s;
            logic [W:0]   full;
            logic         cin, sub, exp_co, exp_ovf, abort;
            int           lat, stall;
            iv = 1'b0; ordy = 1'b0; ai = '0; bi = '0; ci = 1'b0; su = 1'b0;
            abort = 1'b0;
            wait (sweep_go);
            for (int n = 0; n < 1000 && !abort; n++) begin
                a    = W'($urandom);
                b    = W'($urandom);
                cin  = 1'($urandom);
                sub  = 1'($urandom);
                beff = sub ? ~b : b;
                full = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, cin ^ sub};
                exp_s   = full[W-1:0];
                exp_co  = full[W];
                exp_ovf = (a[W-1] == beff[W-1]) && (exp_s[W-1] != a[W-1]);

                @(negedge clk);
                checks++;
                if (ir !== 1'b1) begin
                    errors++;
                    $display("FAIL sweep%0d_in_ready op %0d: got %b expected 1", g, n, ir);
                end
                iv = 1'b1; ai = a; bi = b; ci = cin; su = sub;
                @(posedge clk); #1;
                iv = 1'b0; ai = ~a; bi = ~b; ci = ~cin; su = ~sub;
                lat = 0;
                while (!ov && lat < 100) begin
                    @(posedge clk); #1;
                    lat++;
                end
                checks++;
                if (lat != N) begin
                    errors++;
                    $display("FAIL sweep%0d_latency op %0d: got %0d expected %0d", g, n, lat, N);
                    if (lat >= 100) abort = 1'b1;
                end
                stall = $urandom_range(0, 3);
                repeat (stall) begin
                    @(posedge clk); #1;
                end
                checks++;
                if (ov !== 1'b1 || s !== exp_s || co !== exp_co || vf !== exp_ovf) begin
                    errors++;
                    $display("FAIL sweep%0d_result op %0d a=%h b=%h cin=%b sub=%b: got v=%b S=%h C=%b O=%b expected v=1 S=%h C=%b O=%b",
                             g, n, a, b, cin, sub, ov, s, co, vf, exp_s, exp_co, exp_ovf);
                end
                @(negedge clk); ordy = 1'b1;
                @(posedge clk); #1; ordy = 1'b0;
                checks++;
                if (ov !== 1'b0 || ir !== 1'b1) begin
                    errors++;
                    $display("FAIL sweep%0d_release op %0d: got out_valid=%b in_ready=%b expected 0/1", g, n, ov, ir);
                end
            end
            done = 1'b1;
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic su,
                          output int lat, output logic busy_ok);
        @(negedge clk);
        A = a; B = b; Cin = ci; Sub = su; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; A = ~a; B = ~b; Cin = ~ci; Sub = ~su;
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 50) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) busy_ok = 1'b0;
    endtask

    task automatic release_out();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (S !== 16'h0 || Cout !== 1'b0 || Ovf !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got S=%h C=%b O=%b expected 0000/0/0", S, Cout, Ovf);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic_add();
        int lat; logic busy_ok;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat, busy_ok);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL t1_latency: got %0d expected 4", lat); end
        checks++;
        if (busy_ok !== 1'b1) begin errors++; $display("FAIL t1_in_ready_low: got in_ready high during op, expected low"); end
        checks++;
        if (S !== 16'h5555 || Cout !== 1'b0 || Ovf !== 1'b0) begin
            errors++; $display("FAIL t1_result: got S=%h C=%b O=%b expected 5555/0/0", S, Cout, Ovf);
        end
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL t1_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_vectors(input string name, input logic su,
                                input logic [15:0] ta[3], input logic [15:0] tb[3], input logic tc[3],
                                input logic [15:0] es[3], input logic eco[3], input logic eov[3]);
        int lat; logic busy_ok;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], tc[i], su, lat, busy_ok);
            checks++;
            if (S !== es[i] || Cout !== eco[i] || Ovf !== eov[i]) begin
                errors++;
                $display("FAIL %s_%0d: got S=%h C=%b O=%b expected S=%h C=%b O=%b",
                         name, i, S, Cout, Ovf, es[i], eco[i], eov[i]);
            end
            release_out();
        end
    endtask

    task automatic test_add_boundaries();
        test_vectors("t2_add", 1'b0,
                     '{16'hFFFF, 16'h7FFF, 16'hFFFF}, '{16'h0001, 16'h0001, 16'hFFFF}, '{1'b0, 1'b0, 1'b1},
                     '{16'h0000, 16'h8000, 16'hFFFF}, '{1'b1, 1'b0, 1'b1}, '{1'b0, 1'b1, 1'b0});
    endtask

    task automatic test_subtract();
        test_vectors("t3_sub", 1'b1,
                     '{16'h0005, 16'h8000, 16'h0010}, '{16'h0007, 16'h0001, 16'h0001}, '{1'b0, 1'b0, 1'b1},
                     '{16'hFFFE, 16'h7FFF, 16'h000E}, '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b0});
    endtask

    task automatic test_backpressure();
        int lat; logic busy_ok, stable_ok, idle_ok;
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, lat, busy_ok);
        stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i >= 1 && i <= 3);
            A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; Sub = 1'b0;
            @(posedge clk); #1;
            if (S !== 16'h3333 || Cout !== 1'b0 || Ovf !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0)
                stable_ok = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (stable_ok !== 1'b1) begin
            errors++; $display("FAIL t4_hold: got S=%h C=%b O=%b v=%b r=%b expected 3333/0/0 held, v=1 r=0",
                               S, Cout, Ovf, out_valid, in_ready);
        end
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL t4_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        idle_ok = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || S !== 16'h3333) idle_ok = 1'b0;
        end
        checks++;
        if (idle_ok !== 1'b1) begin
            errors++; $display("FAIL t4_no_queue: got out_valid=%b in_ready=%b S=%h expected 0/1/3333", out_valid, in_ready, S);
        end
        run_op(16'h9000, 16'h9000, 1'b0, 1'b0, lat, busy_ok);
        checks++;
        if (lat !== 4 || S !== 16'h2000 || Cout !== 1'b1 || Ovf !== 1'b1) begin
            errors++; $display("FAIL t4_next_op: got lat=%0d S=%h C=%b O=%b expected 4/2000/1/1", lat, S, Cout, Ovf);
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        int lat; logic busy_ok, quiet_ok;
        @(negedge clk);
        A = 16'h4444; B = 16'h1111; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (S !== 16'h0 || Cout !== 1'b0 || Ovf !== 1'b0) begin
            errors++; $display("FAIL t5_reset_outputs: got S=%h C=%b O=%b expected 0000/0/0", S, Cout, Ovf);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL t5_reset_handshake: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        quiet_ok = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) quiet_ok = 1'b0;
        end
        checks++;
        if (quiet_ok !== 1'b1) begin errors++; $display("FAIL t5_stale_valid: got out_valid=1 after reset expected 0"); end
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat, busy_ok);
        checks++;
        if (lat !== 4 || S !== 16'h0100 || Cout !== 1'b0 || Ovf !== 1'b0) begin
            errors++; $display("FAIL t5_fresh_op: got lat=%0d S=%h C=%b O=%b expected 4/0100/0/0", lat, S, Cout, Ovf);
        end
        release_out();
    endtask

    task automatic test_sweep();
        int cyc = 0;
        sweep_go = 1'b1;
        while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done) && cyc < 60000) begin
            @(posedge clk);
            cyc++;
        end
        checks++;
        if (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done)) begin
            errors++; $display("FAIL t6_sweep_timeout: got incomplete after %0d cycles expected all configs done", cyc);
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0;
        A = 16'h0; B = 16'h0; Cin = 1'b0; Sub = 1'b0;
        test_reset();
        test_basic_add();
        test_add_boundaries();
        test_subtract();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
